// File: rtl/dll_update_ctrl.sv
// DLL update controller: sequences DLL reset and lock acquisition with
// bounded retries, then issues periodic or requested delay-code updates
// while the datapath is idle, capturing the resulting DCNTL code.
module dll_update_ctrl #(
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 1023,
    parameter int UPD_INTERVAL = 256,
    parameter int UPD_PULSE    = 2,
    parameter int MAX_RETRY    = 3
) (
    input  logic       CLKI,
    input  logic       RST,
    input  logic       EN,
    input  logic       DLL_LOCK,
    input  logic       UPD_REQ,
    input  logic       IDLE,
    input  logic [8:0] DCNTL,
    output logic       DLL_RSTN,
    output logic       DLL_UDDCNTL,
    output logic       DLL_ALUHOLD,
    output logic       READY,
    output logic       UPD_DONE,
    output logic [8:0] DCNTL_HOLD,
    output logic       ERR,
    output logic [1:0] RETRY_CNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_RUN       = 3'd3,
        S_UPDATE    = 3'd4,
        S_CAPTURE   = 3'd5,
        S_FAIL      = 3'd6
    } state_e;

    // One shared counter serves RESET length, lock timeout and update pulse width.
    localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CMAX   = (CMAX_A > UPD_PULSE) ? CMAX_A : UPD_PULSE;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int IW     = $clog2(UPD_INTERVAL);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ivl_q, ivl_d;
    logic          pend_q, pend_d;
    logic [1:0]    retry_q, retry_d;
    logic          err_q, err_d;
    logic [8:0]    hold_q, hold_d;
    logic          rstn_q, rstn_d;
    logic          udd_q, udd_d;
    logic          alu_q, alu_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          lock_s1_q, lock_s_q;
    logic          locked_st;

    assign locked_st = (state_q == S_RUN) || (state_q == S_UPDATE) || (state_q == S_CAPTURE);

    // Next-state, counters, update bookkeeping and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ivl_d   = ivl_q;
        pend_d  = pend_q;
        retry_d = retry_q;
        err_d   = err_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        if (!EN) begin
            state_d = S_OFF;
            retry_d = '0;
            cnt_d   = '0;
        end else if (locked_st && !lock_s_q) begin
            state_d = S_RESET;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
                S_RESET: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_RUN;
                        ivl_d   = '0;
                        pend_d  = 1'b1;
                        retry_d = '0;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        cnt_d = '0;
                        if (retry_q < 2'(MAX_RETRY)) begin
                            retry_d = retry_q + 2'd1;
                            state_d = S_RESET;
                        end else begin
                            state_d = S_FAIL;
                            err_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    if (pend_q && IDLE) begin
                        state_d = S_UPDATE;
                        cnt_d   = '0;
                        // Pending is consumed when the update starts, so any
                        // request seen during UPDATE/CAPTURE survives the capture.
                        pend_d  = 1'b0;
                    end else begin
                        if (ivl_q == IW'(UPD_INTERVAL - 1)) begin
                            pend_d = 1'b1;
                        end else begin
                            ivl_d = ivl_q + IW'(1);
                        end
                        if (UPD_REQ) begin
                            pend_d = 1'b1;
                        end
                    end
                end
                S_UPDATE: begin
                    pend_d = pend_q | UPD_REQ;
                    if (cnt_q == CW'(UPD_PULSE - 1)) begin
                        state_d = S_CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    state_d = S_RUN;
                    pend_d  = pend_q | UPD_REQ;
                    ivl_d   = '0;
                    hold_d  = DCNTL;
                    done_d  = 1'b1;
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end

        rstn_d  = (state_d == S_WAIT_LOCK) || (state_d == S_RUN) ||
                  (state_d == S_UPDATE) || (state_d == S_CAPTURE);
        udd_d   = (state_d == S_UPDATE);
        alu_d   = !((state_d == S_RUN) || (state_d == S_CAPTURE));
        ready_d = (state_d == S_RUN) || (state_d == S_UPDATE) || (state_d == S_CAPTURE);
    end

    // State, counters, synchronizer and output registers.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            ivl_q     <= '0;
            pend_q    <= 1'b0;
            retry_q   <= '0;
            err_q     <= 1'b0;
            hold_q    <= '0;
            rstn_q    <= 1'b0;
            udd_q     <= 1'b0;
            alu_q     <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            lock_s1_q <= 1'b0;
            lock_s_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ivl_q     <= ivl_d;
            pend_q    <= pend_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            rstn_q    <= rstn_d;
            udd_q     <= udd_d;
            alu_q     <= alu_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            lock_s1_q <= DLL_LOCK;
            lock_s_q  <= lock_s1_q;
        end
    end

    assign DLL_RSTN    = rstn_q;
    assign DLL_UDDCNTL = udd_q;
    assign DLL_ALUHOLD = alu_q;
    assign READY       = ready_q;
    assign UPD_DONE    = done_q;
    assign DCNTL_HOLD  = hold_q;
    assign ERR         = err_q;
    assign RETRY_CNT   = retry_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_dll_update_ctrl.sv
// Directed bench for dll_update_ctrl: table of timed input/expected-output
// steps for lock-up and periodic update, plus hand sequences for idle
// blocking, requests during update, lock loss, reset mid-update and failure.
module tb_dll_update_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, dll_lock, upd_req, idle;
    logic [8:0] dcntl;
    logic       dll_rstn, dll_uddcntl, dll_aluhold, ready, upd_done, err;
    logic [8:0] dcntl_hold;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    dll_update_ctrl #(
        .RST_CYCLES  (8),
        .LOCK_TIMEOUT(1023),
        .UPD_INTERVAL(256),
        .UPD_PULSE   (2),
        .MAX_RETRY   (3)
    ) dut (
        .CLKI       (clk),
        .RST        (rst),
        .EN         (en),
        .DLL_LOCK   (dll_lock),
        .UPD_REQ    (upd_req),
        .IDLE       (idle),
        .DCNTL      (dcntl),
        .DLL_RSTN   (dll_rstn),
        .DLL_UDDCNTL(dll_uddcntl),
        .DLL_ALUHOLD(dll_aluhold),
        .READY      (ready),
        .UPD_DONE   (upd_done),
        .DCNTL_HOLD (dcntl_hold),
        .ERR        (err),
        .RETRY_CNT  (retry_cnt),
        .STATE      (state)
    );

    always #5 clk = ~clk;

    // in = {rst, en, lock, idle, req}; o = {rstn, udd, aluhold, ready, done, err}
    typedef struct {
        logic [4:0] in;
        int         cyc;
        logic [2:0] st;
        logic [5:0] o;
        logic [1:0] retry;
        logic [8:0] hold;
    } vec_t;

    vec_t tbl[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({dll_rstn, dll_uddcntl, dll_aluhold, ready, upd_done, err});
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int udd_cnt, done_cnt, not_run, t, t_first, entries, rst_run;
        logic [2:0] prev;

        tbl[0]  = '{5'b10000,   3, 3'd0, 6'b001000, 2'd0, 9'h000}; // reset
        tbl[1]  = '{5'b01000,   1, 3'd1, 6'b001000, 2'd0, 9'h000}; // OFF->RESET
        tbl[2]  = '{5'b01000,   7, 3'd1, 6'b001000, 2'd0, 9'h000}; // 8th RESET cycle
        tbl[3]  = '{5'b01000,   1, 3'd2, 6'b101000, 2'd0, 9'h000}; // WAIT_LOCK, RSTN=1
        tbl[4]  = '{5'b01000,  49, 3'd2, 6'b101000, 2'd0, 9'h000}; // 50 cycles unlocked
        tbl[5]  = '{5'b01100,   2, 3'd2, 6'b101000, 2'd0, 9'h000}; // lock in synchronizer
        tbl[6]  = '{5'b01100,   1, 3'd3, 6'b100100, 2'd0, 9'h000}; // RUN, READY
        tbl[7]  = '{5'b01100,   5, 3'd3, 6'b100100, 2'd0, 9'h000}; // IDLE=0 holds RUN
        tbl[8]  = '{5'b01110,   1, 3'd4, 6'b111100, 2'd0, 9'h000}; // UPDATE cycle 1
        tbl[9]  = '{5'b01110,   1, 3'd4, 6'b111100, 2'd0, 9'h000}; // UPDATE cycle 2
        tbl[10] = '{5'b01110,   1, 3'd5, 6'b100100, 2'd0, 9'h000}; // CAPTURE
        tbl[11] = '{5'b01110,   1, 3'd3, 6'b100110, 2'd0, 9'h0A5}; // UPD_DONE, code held
        tbl[12] = '{5'b01110, 256, 3'd3, 6'b100100, 2'd0, 9'h0A5}; // interval running
        tbl[13] = '{5'b01110,   1, 3'd4, 6'b111100, 2'd0, 9'h0A5}; // periodic UPDATE
        tbl[14] = '{5'b01110,   2, 3'd5, 6'b100100, 2'd0, 9'h0A5}; // CAPTURE
        tbl[15] = '{5'b01110,   1, 3'd3, 6'b100110, 2'd0, 9'h0A5}; // 260 cycles apart

        rst = 1'b1; en = 1'b0; dll_lock = 1'b0; upd_req = 1'b0; idle = 1'b0;
        dcntl = 9'h0A5;

        for (int i = 0; i < 16; i++) begin
            {rst, en, dll_lock, idle, upd_req} = tbl[i].in;
            repeat (tbl[i].cyc) tick();
            chk($sformatf("v%0d state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("v%0d outs", i), outs(), int'(tbl[i].o));
            chk($sformatf("v%0d retry", i), int'(retry_cnt), int'(tbl[i].retry));
            chk($sformatf("v%0d hold", i), int'(dcntl_hold), int'(tbl[i].hold));
        end

        // IDLE=0 for 1000 cycles with a request: nothing may start.
        idle = 1'b0; udd_cnt = 0; not_run = 0;
        for (int i = 0; i < 1000; i++) begin
            upd_req = (i == 100);
            tick();
            if (dll_uddcntl) udd_cnt++;
            if (state != 3'd3) not_run++;
        end
        upd_req = 1'b0;
        chk("idle0 uddcntl", udd_cnt, 0);
        chk("idle0 stays run", not_run, 0);
        idle = 1'b1; udd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dll_uddcntl) udd_cnt++;
            if (upd_done) done_cnt++;
        end
        chk("idle1 uddcntl cycles", udd_cnt, 2);
        chk("idle1 single update", done_cnt, 1);

        // Request during UPDATE must produce a back-to-back second update.
        upd_req = 1'b1; tick();
        upd_req = 1'b0; tick();
        chk("req starts update", int'(state), 4);
        upd_req = 1'b1; tick();
        upd_req = 1'b0;
        udd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dll_uddcntl) udd_cnt++;
            if (upd_done) done_cnt++;
        end
        chk("req in update done", done_cnt, 2);
        chk("req in update udd", udd_cnt, 2);

        // Lock lost as an update begins: abort to RESET without capture.
        dcntl = 9'h1FF; dll_lock = 1'b0; upd_req = 1'b1; tick();
        upd_req = 1'b0; tick();
        chk("lockloss in update", int'(state), 4);
        tick();
        chk("lockloss state", int'(state), 1);
        chk("lockloss outs", outs(), int'(6'b001000));
        chk("lockloss hold", int'(dcntl_hold), 9'h0A5);
        chk("lockloss retry", int'(retry_cnt), 0);

        // Relock, then assert RST in the middle of UPDATE.
        dll_lock = 1'b1;
        t = 0;
        while (state != 3'd4 && t < 40) begin
            tick();
            t++;
        end
        chk("relock reach update", int'(state), 4);
        rst = 1'b1; tick();
        chk("rst mid-update state", int'(state), 0);
        chk("rst mid-update outs", outs(), int'(6'b001000));
        chk("rst mid-update hold", int'(dcntl_hold), 0);
        chk("rst mid-update retry", int'(retry_cnt), 0);

        // Never locking: four RESET/WAIT sequences, then FAIL.
        rst = 1'b0; dll_lock = 1'b0; en = 1'b1;
        prev = state; t = 0; t_first = -1; entries = 0; rst_run = 0;
        while (state != 3'd6 && t < 6000) begin
            tick();
            t++;
            if (state == 3'd1) rst_run++;
            else if (rst_run != 0) begin
                chk("reset run length", rst_run, 8);
                rst_run = 0;
            end
            if (state == 3'd2 && prev != 3'd2) begin
                chk($sformatf("retry at wait %0d", entries), int'(retry_cnt), entries);
                entries++;
                if (t_first < 0) t_first = t;
            end
            prev = state;
        end
        chk("fail reached", int'(state), 6);
        chk("wait entries", entries, 4);
        chk("fail timing", t - t_first, 4 * 1023 + 3 * 8);
        chk("fail outs", outs(), int'(6'b001001));
        chk("fail retry", int'(retry_cnt), 3);
        repeat (5) tick();
        chk("fail sticky", int'(state), 6);
        en = 1'b0; tick();
        chk("en0 state", int'(state), 0);
        chk("en0 err kept", int'(err), 1);
        chk("en0 retry", int'(retry_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dll_update_ctrl.md
DLL_UPDATE_CTRL -- requirements
Module: dll_update_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 8: DLL reset assertion length in CLKI cycles (min 1).
REQ-002 Parameter LOCK_TIMEOUT, default 1023: cycles waited for lock per attempt (min 1).
REQ-003 Parameter UPD_INTERVAL, default 256: cycles between periodic delay-code updates (min 4).
REQ-004 Parameter UPD_PULSE, default 2: UDDCNTL pulse width in cycles (min 1).
REQ-005 Parameter MAX_RETRY, default 3: lock attempts after the first before failure (0..3).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 CLKI  in  1  block clock; all state changes on its rising edge.
REQ-008 RST  in  1  synchronous, active-high reset.
REQ-009 EN  in  1  level enable; 0 parks the DLL in reset.
REQ-010 DLL_LOCK  in  1  DLL LOCK output; asynchronous to CLKI.
REQ-011 UPD_REQ  in  1  single-cycle request for an immediate code update.
REQ-012 IDLE  in  1  datapath quiet; an update is allowed only while high.
REQ-013 DCNTL  in  9  DLL delay-control code.
REQ-014 DLL_RSTN  out  1  DLL reset, active-low.
REQ-015 DLL_UDDCNTL  out  1  DLL code-update enable.
REQ-016 DLL_ALUHOLD  out  1  DLL ALU hold.
REQ-017 READY  out  1  DLL locked; the delay code is usable.
REQ-018 UPD_DONE  out  1  one-cycle pulse when a new code is captured.
REQ-019 DCNTL_HOLD  out  9  last captured delay code.
REQ-020 ERR  out  1  sticky lock failure.
REQ-021 RETRY_CNT  out  2  retries used in the current lock sequence.
REQ-022 STATE  out  3  FSM state encoding.

Function
REQ-023 DLL_LOCK SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized lock_s, so response to an input edge takes 2-3 cycles.
REQ-024 FSM states and encodings SHALL be OFF=0, RESET=1, WAIT_LOCK=2, RUN=3, UPDATE=4, CAPTURE=5, FAIL=6.
REQ-025 Transition priority SHALL be: RST, then EN=0, then loss of lock_s, then timeout, then the normal transition.
REQ-026 OFF: DLL_RSTN=0, DLL_ALUHOLD=1; with EN=1, go to RESET on the next cycle.
REQ-027 RESET: DLL_RSTN=0 for exactly RST_CYCLES cycles, then go to WAIT_LOCK; DLL_RSTN=1 in the first WAIT_LOCK cycle.
REQ-028 WAIT_LOCK: timeout counter starts at 0 on entry and increments each cycle; lock_s=1 goes to RUN.
REQ-029 WAIT_LOCK timeout when the counter reaches LOCK_TIMEOUT-1 without lock_s: if RETRY_CNT<MAX_RETRY, increment RETRY_CNT and go to RESET; otherwise go to FAIL and set ERR=1.
REQ-030 Entering RUN SHALL set READY=1 and DLL_ALUHOLD=0, clear RETRY_CNT, clear the interval counter, and set update-pending.
- Setting update-pending on entry makes the first code capture happen after lock.
REQ-031 RUN: the interval counter increments and saturates at UPD_INTERVAL-1; reaching UPD_INTERVAL-1 sets update-pending.
REQ-032 UPD_REQ=1 in any of RUN, UPDATE or CAPTURE SHALL set update-pending; a request arriving during UPDATE or CAPTURE is serviced after returning to RUN.
REQ-033 RUN with update-pending=1 and IDLE=1 goes to UPDATE; with IDLE=0 the block waits indefinitely in RUN.
REQ-034 UPDATE: DLL_UDDCNTL=1 and DLL_ALUHOLD=1 for exactly UPD_PULSE cycles, then go to CAPTURE; READY stays 1.
REQ-035 CAPTURE (one cycle): DCNTL_HOLD<=DCNTL, UPD_DONE=1, clear update-pending (unless UPD_REQ=1 in the same cycle), clear the interval counter, DLL_ALUHOLD=0, return to RUN.
REQ-036 Loss of lock_s in RUN, UPDATE or CAPTURE:
- next cycle: READY=0, DLL_UDDCNTL=0, DLL_ALUHOLD=1, go to RESET;
- RETRY_CNT unchanged; no UPD_DONE; DCNTL_HOLD retained.
REQ-037 FAIL: DLL_RSTN=0, READY=0; exit only via RST or EN=0.
REQ-038 EN=0 in any state goes to OFF on the next cycle:
- DLL_RSTN=0, DLL_UDDCNTL=0, DLL_ALUHOLD=1, READY=0, RETRY_CNT=0;
- ERR and DCNTL_HOLD retained.
REQ-039 All outputs SHALL be registered.

Reset
REQ-040 RST=1 at a clock edge SHALL force the following on the next cycle, in any state including mid-UPDATE:
- STATE=OFF, DLL_RSTN=0, DLL_UDDCNTL=0, DLL_ALUHOLD=1;
- READY=0, UPD_DONE=0, DCNTL_HOLD=0, ERR=0, RETRY_CNT=0;
- synchronizer flops, all counters and update-pending cleared.

Verification
REQ-041 Defaults; EN=1; DLL_LOCK rises 50 cycles after DLL_RSTN=1 -> DLL_RSTN low exactly 8 cycles; READY=1 2-3 cycles after the lock edge; first UPD_DONE after 2 UDDCNTL cycles; DCNTL_HOLD=DCNTL.
REQ-042 Locked, IDLE=1, DCNTL=9'h0A5 -> UPD_DONE every 256+2+1+1 cycles; DCNTL_HOLD=9'h0A5.
REQ-043 DLL_LOCK never asserts -> 4 reset/wait sequences (RETRY_CNT 0,1,2,3), then STATE=6, ERR=1; EN=0 -> STATE=0, ERR stays 1.
REQ-044 Locked, IDLE=0 for 1000 cycles with a UPD_REQ pulse -> no UDDCNTL; IDLE=1 -> exactly one update; a UPD_REQ issued during UPDATE -> a second update follows immediately.
REQ-045 DLL_LOCK drops during UPDATE -> READY=0, UDDCNTL=0 within 3 cycles; no UPD_DONE; DCNTL_HOLD unchanged; RESET re-entered.
REQ-046 RST=1 mid-UPDATE -> next cycle all outputs at REQ-040 values.
